cpu_run_controller: RTL and testbench

- Drives the CPU side of the run/reset interface, i.e. the `clk`/`reset` handshake into `cpu_pipelined`, as synthesizable RTL.
- Sequences the CPU's synchronous reset, releases it to run, and counts executed cycles.
- Stops the run on a halt indication from the CPU or on a cycle-budget timeout.
- Sits between the board/SoC control logic and `cpu_pipelined`; replaces fixed-delay reset/run sequencing.

---
 rtl/cpu_run_controller_if.sv | 38 +++
 rtl/cpu_run_controller.sv | 139 +++++++++++++
 tb/tb_cpu_run_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_run_controller_if
// Purpose : bundles the control/status signals exchanged between the board/SoC
//           control logic (master) and the CPU run controller (slave).
// Signals :
//   start        master->slave  request to begin a run
//   abort        master->slave  synchronous abort back to IDLE
//   halt_in      master->slave  CPU retired a halt instruction this cycle
//   cycle_budget master->slave  cycle limit for the run (0 selects default)
//   cpu_reset    slave->master  synchronous reset driven into the CPU
//   running      slave->master  run in progress
//   done         slave->master  run finished
//   timeout      slave->master  run finished on budget (valid with done)
//   cycle_count  slave->master  RUN cycles elapsed
// -----------------------------------------------------------------------------
interface cpu_run_controller_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic             halt_in;
    logic [CNT_W-1:0] cycle_budget;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, abort, halt_in, cycle_budget,
        input  cpu_reset, running, done, timeout, cycle_count
    );

    modport slave (
        input  start, abort, halt_in, cycle_budget,
        output cpu_reset, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
// Purpose : sequences the synchronous reset of the pipelined CPU, releases it
//           to run, counts executed cycles and stops the run on a CPU halt or
//           when the cycle budget is used up.
// Ports   :
//   clk    input  system clock, rising edge
//   reset  input  asynchronous active-high reset of this block
//   ctl    slave modport of cpu_run_controller_if (start/abort/halt_in/
//          cycle_budget in; cpu_reset/running/done/timeout/cycle_count out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int RESET_CYCLES = 1,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_controller_if.slave  ctl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] W_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] W_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_BUDGET = CNT_W'(MAX_CYCLES);
    localparam logic [7:0]       HOLD_INIT  = 8'(RESET_CYCLES);

    state_t           r_state;
    logic [7:0]       r_hold;
    logic [CNT_W-1:0] r_budget;
    logic [CNT_W-1:0] r_count;
    logic             r_timeout;
    logic             r_cpu_reset;
    logic             r_running;
    logic             r_done;

    state_t           w_state_nxt;
    logic [7:0]       w_hold_nxt;
    logic [CNT_W-1:0] w_budget_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_timeout_nxt;

    // Next-state and next-value logic; abort overrides every other input.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_budget_nxt  = r_budget;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;

        if (ctl.abort) begin
            w_state_nxt   = S_IDLE;
            w_count_nxt   = W_ZERO;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ctl.start) begin
                        w_state_nxt   = S_HOLD;
                        w_hold_nxt    = HOLD_INIT;
                        // A zero budget selects the default limit, so the
                        // latched budget is never zero inside RUN.
                        w_budget_nxt  = (ctl.cycle_budget == W_ZERO) ? MAX_BUDGET
                                                                     : ctl.cycle_budget;
                        w_count_nxt   = W_ZERO;
                        w_timeout_nxt = 1'b0;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_HOLD: begin
                    // <= 1 also releases a counter that was somehow left at 0.
                    if (r_hold <= 8'd1) begin
                        w_state_nxt = S_RUN;
                        w_hold_nxt  = 8'd0;
                    end else begin
                        w_hold_nxt  = r_hold - 8'd1;
                    end
                end
                S_RUN: begin
                    // The halting / final cycle is counted too.
                    w_count_nxt = r_count + W_ONE;
                    if (ctl.halt_in) begin
                        w_state_nxt   = S_DONE;
                        w_timeout_nxt = 1'b0;
                    end else if (r_count == (r_budget - W_ONE)) begin
                        w_state_nxt   = S_DONE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = W_ZERO;
                    w_timeout_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold      <= 8'd0;
            r_budget    <= W_ZERO;
            r_count     <= W_ZERO;
            r_timeout   <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_budget    <= w_budget_nxt;
            r_count     <= w_count_nxt;
            r_timeout   <= w_timeout_nxt;
            r_cpu_reset <= (w_state_nxt != S_RUN);
            r_running   <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign ctl.cpu_reset   = r_cpu_reset;
    assign ctl.running     = r_running;
    assign ctl.done        = r_done;
    assign ctl.timeout     = r_timeout;
    assign ctl.cycle_count = r_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_controller
// Two controllers (RESET_CYCLES = 1 and 3) share one stimulus stream.  The
// expected outputs come from an edge-index model: a run is described by the
// edge it started on, whether/when it ended and how; outputs are derived from
// the distance between the current edge and the start edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_controller;

    localparam int CNT_W = 32;
    localparam int MAXC  = 2000;
    localparam int RC0   = 1;
    localparam int RC1   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s, abort_s, halt_s;
    logic [31:0] budget_s;

    always #5 clk = ~clk;

    cpu_run_controller_if #(.CNT_W(CNT_W)) bus0 ();
    cpu_run_controller_if #(.CNT_W(CNT_W)) bus1 ();

    assign bus0.start = start_s;  assign bus0.abort = abort_s;
    assign bus0.halt_in = halt_s; assign bus0.cycle_budget = budget_s;
    assign bus1.start = start_s;  assign bus1.abort = abort_s;
    assign bus1.halt_in = halt_s; assign bus1.cycle_budget = budget_s;

    cpu_run_controller #(.RESET_CYCLES(RC0), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) u_dut0 (
        .clk(clk), .reset(reset), .ctl(bus0));
    cpu_run_controller #(.RESET_CYCLES(RC1), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) u_dut1 (
        .clk(clk), .reset(reset), .ctl(bus1));

    int n_total = 0;
    int n_pass  = 0;
    int run_len0;

    // reference model state
    int t;
    int rcs      [2];
    int m_start  [2];
    bit m_ended  [2];
    int m_end_cnt[2];
    bit m_tout   [2];
    int m_budget [2];

    localparam logic [35:0] RST_VEC = {4'b1000, 32'd0};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, expv, t);
    endtask

    function automatic bit m_busy(int d);
        return (m_start[d] >= 0) && !m_ended[d];
    endfunction

    function automatic bit m_running(int d);
        return m_busy(d) && ((t - m_start[d]) >= rcs[d]);
    endfunction

    // {cpu_reset, running, done, timeout, cycle_count}
    function automatic logic [35:0] exp_vec(int d);
        if (m_start[d] < 0) return RST_VEC;
        if (m_ended[d]) return {1'b1, 1'b0, 1'b1, m_tout[d], 32'(m_end_cnt[d])};
        if ((t - m_start[d]) < rcs[d]) return RST_VEC;
        return {4'b0100, 32'(t - m_start[d] - rcs[d])};
    endfunction

    function automatic int m_count(int d);
        logic [35:0] v;
        v = exp_vec(d);
        return int'(v[31:0]);
    endfunction

    function automatic logic [35:0] obs_vec(int d);
        if (d == 0) return {bus0.cpu_reset, bus0.running, bus0.done, bus0.timeout, bus0.cycle_count};
        return {bus1.cpu_reset, bus1.running, bus1.done, bus1.timeout, bus1.cycle_count};
    endfunction

    task automatic model_reset();
        t = 0;
        for (int d = 0; d < 2; d++) begin
            m_start[d] = -1; m_ended[d] = 1'b0; m_end_cnt[d] = 0; m_tout[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit pr[2];
        int r;
        for (int d = 0; d < 2; d++) pr[d] = m_running(d);
        t++;
        for (int d = 0; d < 2; d++) begin
            if (abort_s) begin
                m_start[d] = -1; m_ended[d] = 1'b0;
            end else if (!m_busy(d) && start_s) begin
                m_start[d]  = t; m_ended[d] = 1'b0; m_tout[d] = 1'b0;
                m_budget[d] = (budget_s == 32'd0) ? MAXC : int'(budget_s);
            end else if (pr[d]) begin
                r = t - m_start[d] - rcs[d];
                if (halt_s) begin
                    m_ended[d] = 1'b1; m_end_cnt[d] = r; m_tout[d] = 1'b0;
                end else if (r == m_budget[d]) begin
                    m_ended[d] = 1'b1; m_end_cnt[d] = r; m_tout[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (bus0.running) run_len0++;
        check_eq("dut0_cycle", obs_vec(0), exp_vec(0));
        check_eq("dut1_cycle", obs_vec(1), exp_vec(1));
    endtask

    task automatic clear_inputs();
        start_s = 1'b0; abort_s = 1'b0; halt_s = 1'b0;
    endtask

    task automatic finish_run(input int bound);
        int g = 0;
        clear_inputs();
        while ((m_busy(0) || m_busy(1)) && g < bound) begin
            step(); g++;
        end
        if (m_busy(0) || m_busy(1)) check_eq("run_bound", 64'(g), 64'(bound + 1));
    endtask

    task automatic run_once(input int budget, input int halt_at, input bit noise);
        int g = 0;
        int beff;
        beff = (budget == 0) ? MAXC : budget;
        run_len0 = 0;
        budget_s = 32'(budget); start_s = 1'b1;
        step();
        start_s  = 1'b0;
        budget_s = $urandom;
        while ((m_busy(0) || m_busy(1)) && g < beff + 20) begin
            clear_inputs();
            if (m_running(0) && halt_at > 0 && m_count(0) == halt_at - 1) halt_s = 1'b1;
            if (noise) begin
                if (!m_running(0)) halt_s = 1'($urandom_range(0, 1));
                if (m_busy(0) && m_busy(1)) start_s = ($urandom_range(0, 5) == 0);
                abort_s = ($urandom_range(0, 80) == 0);
            end
            step(); g++;
        end
        if (m_busy(0) || m_busy(1)) check_eq("run_bound", 64'(g), 64'(beff + 21));
        clear_inputs();
        step(); step();
    endtask

    initial begin
        int b, h, g;
        rcs[0] = RC0; rcs[1] = RC1;
        model_reset();
        clear_inputs();
        budget_s = 32'd0;
        reset = 1'b1;
        #2;
        check_eq("rst_dut0", obs_vec(0), RST_VEC);
        check_eq("rst_dut1", obs_vec(1), RST_VEC);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // start at edge 3, cpu_reset falls at edge 4
        step(); step();
        budget_s = 32'd20; start_s = 1'b1;
        step();
        check_eq("e3_cpu_reset", 64'(bus0.cpu_reset), 64'd1);
        start_s = 1'b0;
        step();
        check_eq("e4_release", 64'({bus0.cpu_reset, bus0.running}), 64'(2'b01));
        finish_run(60);

        // halt on the 10th RUN edge
        run_once(100, 10, 1'b0);
        check_eq("halt_cnt", 64'(bus0.cycle_count), 64'd10);
        check_eq("halt_flags", 64'({bus0.cpu_reset, bus0.running, bus0.done, bus0.timeout}), 64'(4'b1010));

        // budget timeout
        run_once(5, 0, 1'b0);
        check_eq("to5_cnt", 64'(bus0.cycle_count), 64'd5);
        check_eq("to5_flag", 64'(bus0.timeout), 64'd1);
        check_eq("to5_runlen", 64'(run_len0), 64'd5);

        // zero budget selects the default
        run_once(0, 0, 1'b0);
        check_eq("to0_cnt", 64'(bus0.cycle_count), 64'd2000);
        check_eq("to0_flag", 64'(bus0.timeout), 64'd1);
        check_eq("to0_runlen", 64'(run_len0), 64'd2000);

        // halt and budget on the same edge
        run_once(8, 8, 1'b0);
        check_eq("tie_cnt", 64'(bus0.cycle_count), 64'd8);
        check_eq("tie_flag", 64'(bus0.timeout), 64'd0);

        // restart from DONE on the RESET_CYCLES=3 instance
        budget_s = 32'd30; start_s = 1'b1;
        step();
        start_s = 1'b0;
        check_eq("rs_done", 64'(bus1.done), 64'd0);
        check_eq("rs_cnt", 64'(bus1.cycle_count), 64'd0);
        step(); step();
        check_eq("rs_hold", 64'(bus1.cpu_reset), 64'd1);
        step();
        check_eq("rs_release", 64'({bus1.cpu_reset, bus1.running}), 64'(2'b01));
        finish_run(60);

        // abort together with start on the 3rd RUN edge
        budget_s = 32'd50; start_s = 1'b1;
        step();
        start_s = 1'b0; g = 0;
        while (!(m_running(0) && m_count(0) == 2) && g < 20) begin step(); g++; end
        abort_s = 1'b1; start_s = 1'b1;
        step();
        check_eq("abort_dut0", obs_vec(0), RST_VEC);
        check_eq("abort_dut1", obs_vec(1), RST_VEC);
        clear_inputs();
        step(); step();

        // async reset between edges during RUN
        budget_s = 32'd50; start_s = 1'b1;
        step();
        start_s = 1'b0; g = 0;
        while (!(m_running(0) && m_count(0) == 5) && g < 20) begin step(); g++; end
        #3 reset = 1'b1;
        #1;
        check_eq("arst_dut0", obs_vec(0), RST_VEC);
        check_eq("arst_dut1", obs_vec(1), RST_VEC);
        model_reset();
        #1 reset = 1'b0;
        step(); step();

        // randomized runs with noise on start/halt/abort
        for (int i = 0; i < 25; i++) begin
            b = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 40));
            h = (b == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, b + 3));
            run_once(b, h, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
